// File: rtl/ccff_prog_ctrl.sv
// rtl/ccff_prog_ctrl.sv - configuration-chain programming sequencer with optional read-back compare
module ccff_prog_ctrl #(
    parameter int WORD_W   = 32,
    parameter int ADDR_W   = 10,
    parameter int CNT_W    = 16,
    parameter int HALF_PER = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              verify,
    input  logic              abort,
    input  logic [CNT_W-1:0]  cfg_nbits,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              prog_clk,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_cnt
);

    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int HC_W  = (HALF_PER > 1) ? $clog2(HALF_PER) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W - 1);
    localparam logic [HC_W-1:0]  HC_LAST  = HC_W'(HALF_PER - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SHIFT_LO,
        S_SHIFT_HI,
        S_DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [ADDR_W-1:0]  addr;
    logic [CNT_W-1:0]   bit_cnt;
    logic [CNT_W-1:0]   nbits;
    logic               verify_q;
    logic               pass_no;
    logic [WORD_W-1:0]  word;
    logic [IDX_W-1:0]   word_idx;
    logic [HC_W-1:0]    hcnt;

    logic               half_last;
    logic               stop;
    logic [CNT_W-1:0]   bit_cnt_inc;
    logic [IDX_W-1:0]   idx_inc;

    assign half_last   = (hcnt == HC_LAST);
    assign stop        = abort && (state != S_IDLE);
    assign bit_cnt_inc = bit_cnt + CNT_W'(1);
    assign idx_inc     = word_idx + IDX_W'(1);
    assign mem_req     = (state == S_FETCH);
    assign mem_addr    = addr;

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (start) state_nxt = (cfg_nbits == '0) ? S_DONE : S_FETCH;
            S_FETCH:    if (mem_ack) state_nxt = S_SHIFT_LO;
            S_SHIFT_LO: if (half_last) state_nxt = S_SHIFT_HI;
            S_SHIFT_HI: begin
                if (half_last) begin
                    if (bit_cnt_inc == nbits)
                        state_nxt = (verify_q && !pass_no) ? S_FETCH : S_DONE;
                    else if (word_idx == IDX_LAST)
                        state_nxt = S_FETCH;
                    else
                        state_nxt = S_SHIFT_LO;
                end
            end
            S_DONE:     state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
        if (stop) state_nxt = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr      <= '0;
            bit_cnt   <= '0;
            nbits     <= '0;
            verify_q  <= 1'b0;
            pass_no   <= 1'b0;
            word      <= '0;
            word_idx  <= '0;
            hcnt      <= '0;
            prog_clk  <= 1'b0;
            ccff_head <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_cnt   <= '0;
        end else begin
            prog_clk <= (state_nxt == S_SHIFT_HI);
            busy     <= (state_nxt inside {S_FETCH, S_SHIFT_LO, S_SHIFT_HI});
            done     <= (state_nxt == S_DONE);
            hcnt     <= (state_nxt == state) ? hcnt + HC_W'(1) : '0;
            if (stop) begin
                pass <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            nbits    <= cfg_nbits;
                            verify_q <= verify;
                            pass_no  <= 1'b0;
                            addr     <= '0;
                            bit_cnt  <= '0;
                            err_cnt  <= '0;
                            pass     <= (cfg_nbits == '0);
                        end
                    end
                    S_FETCH: begin
                        if (mem_ack) begin
                            word      <= mem_rdata;
                            word_idx  <= '0;
                            addr      <= addr + ADDR_W'(1);
                            ccff_head <= mem_rdata[0];
                        end
                    end
                    S_SHIFT_LO: begin
                        // tail is sampled just before the rising edge that would shift it out
                        if (half_last && pass_no && (ccff_tail != word[word_idx])
                            && (err_cnt != 16'hFFFF))
                            err_cnt <= err_cnt + 16'd1;
                    end
                    S_SHIFT_HI: begin
                        if (half_last) begin
                            bit_cnt <= bit_cnt_inc;
                            if (bit_cnt_inc == nbits) begin
                                if (verify_q && !pass_no) begin
                                    pass_no <= 1'b1;
                                    addr    <= '0;
                                    bit_cnt <= '0;
                                end else begin
                                    pass <= (err_cnt == 16'd0);
                                end
                            end else if (word_idx != IDX_LAST) begin
                                word_idx  <= idx_inc;
                                ccff_head <= word[idx_inc];
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ccff_prog_ctrl.sv
// tb/tb_ccff_prog_ctrl.sv - self-checking bench for ccff_prog_ctrl
module tb_ccff_prog_ctrl;
    localparam int WORD_W   = 32;
    localparam int ADDR_W   = 10;
    localparam int CNT_W    = 16;
    localparam int HALF_PER = 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              verify = 1'b0;
    logic              abort = 1'b0;
    logic [CNT_W-1:0]  cfg_nbits = '0;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack = 1'b0;
    logic [WORD_W-1:0] mem_rdata = '0;
    logic              prog_clk;
    logic              ccff_head;
    logic              ccff_tail;
    logic              busy;
    logic              done;
    logic              pass;
    logic [15:0]       err_cnt;

    ccff_prog_ctrl #(
        .WORD_W(WORD_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .HALF_PER(HALF_PER)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .verify(verify), .abort(abort),
        .cfg_nbits(cfg_nbits), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .prog_clk(prog_clk),
        .ccff_head(ccff_head), .ccff_tail(ccff_tail), .busy(busy), .done(done),
        .pass(pass), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [WORD_W-1:0] mem [0:15];
    int ack_delay = 0;
    bit force0 = 1'b0;
    int tail_idx = 0;
    int flip_at = -1;
    int clr_req = 0;

    // fabric chain: first-in bit travels towards the tail
    logic [127:0] chain = '0;
    int rises_total = 0;
    always @(posedge prog_clk) begin
        chain       <= {chain[126:0], ccff_head};
        rises_total <= rises_total + 1;
    end
    assign ccff_tail = force0 ? 1'b0 : (chain[tail_idx[6:0]] ^ (rises_total == flip_at));

    initial begin : responder
        int wait_cnt;
        wait_cnt = 0;
        forever begin
            @(negedge clk);
            if (mem_req && !mem_ack) begin
                if (wait_cnt >= ack_delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem[mem_addr[3:0]];
                    wait_cnt  = 0;
                end else begin
                    wait_cnt++;
                    mem_rdata = $urandom;
                end
            end else begin
                mem_ack  = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    int rises = 0, done_cnt = 0, done_cyc = 0, req_cnt = 0;
    int bad_hi = 0, bad_stall = 0, bad_addr = 0, hi_run = 0, cyc = 0;
    bit head_q[$];
    int fetch_q[$];

    initial begin : monitor
        int clr_seen;
        logic prev_pc, prev_req;
        logic [ADDR_W-1:0] prev_addr;
        clr_seen = 0; prev_pc = 1'b0; prev_req = 1'b0; prev_addr = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (clr_req != clr_seen) begin
                clr_seen = clr_req;
                rises = 0; done_cnt = 0; done_cyc = 0; req_cnt = 0;
                bad_hi = 0; bad_stall = 0; bad_addr = 0; hi_run = 0;
                head_q.delete();
                fetch_q.delete();
            end
            if (prog_clk && !prev_pc) begin
                rises++;
                head_q.push_back(ccff_head);
            end
            if (prog_clk) hi_run++;
            else if (hi_run != 0) begin
                if (hi_run != HALF_PER) bad_hi++;
                hi_run = 0;
            end
            if (mem_req) begin
                req_cnt++;
                if (prog_clk) bad_stall++;
            end
            if (mem_req && prev_req && !mem_ack && (mem_addr != prev_addr)) bad_addr++;
            if (mem_ack && prev_req) fetch_q.push_back(int'(prev_addr));
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            prev_pc = prog_clk; prev_req = mem_req; prev_addr = mem_addr;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit stream_bit(input int k);
        logic [WORD_W-1:0] w;
        w = mem[k / WORD_W];
        return w[k % WORD_W];
    endfunction

    task automatic do_run(input int n, input bit vf, input int dly, input bit f0,
                          input int flipk, input string tag, output int lat);
        int npass, nw, exp_err, mism, start_cyc;
        ack_delay = dly;
        force0    = f0;
        tail_idx  = (n > 0) ? n - 1 : 0;
        flip_at   = (flipk >= 0) ? rises_total + n + flipk : -1;
        clr_req++;
        start = 1'b1; verify = vf; cfg_nbits = CNT_W'(n);
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0; verify = ~vf;
        for (int c = 0; c < 20000 && done_cnt == 0; c++) @(negedge clk);
        @(negedge clk);
        lat   = done_cyc - start_cyc;
        npass = vf ? 2 : 1;
        nw    = (n + WORD_W - 1) / WORD_W;
        chk({tag, "_done_pulses"}, done_cnt, 1);
        chk({tag, "_rises"}, rises, n * npass);
        mism = 0;
        if (head_q.size() != n * npass) mism = -1;
        else for (int i = 0; i < n * npass; i++)
            if (head_q[i] != stream_bit(i % n)) mism++;
        chk({tag, "_head_mismatches"}, mism, 0);
        mism = 0;
        if (fetch_q.size() != nw * npass) mism = -1;
        else for (int j = 0; j < nw * npass; j++)
            if (fetch_q[j] != j % nw) mism++;
        chk({tag, "_fetch_mismatches"}, mism, 0);
        exp_err = 0;
        if (vf && f0) for (int i = 0; i < n; i++) exp_err += int'(stream_bit(i));
        else if (vf && flipk >= 0) exp_err = 1;
        chk({tag, "_err_cnt"}, err_cnt, exp_err);
        chk({tag, "_pass"}, pass, (exp_err == 0));
        chk({tag, "_busy_after"}, busy, 0);
        chk({tag, "_protocol_faults"}, bad_hi + bad_stall + bad_addr, 0);
        force0  = 1'b0;
        flip_at = -1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_mem_req"}, mem_req, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_prog_clk"}, prog_clk, 0);
        chk({tag, "_ccff_head"}, ccff_head, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_pass"}, pass, 0);
        chk({tag, "_err_cnt"}, err_cnt, 0);
    endtask

    initial begin : main
        int lat, n, flipk;
        bit vf;
        logic [7:0] hv;
        for (int i = 0; i < 16; i++) mem[i] = $urandom;

        repeat (3) @(negedge clk);
        chk_reset_outputs("por");
        reset = 1'b0;
        @(negedge clk);

        mem[0] = 32'h0000_00A5;
        do_run(8, 1'b0, 0, 1'b0, -1, "a5", lat);
        hv = '0;
        for (int i = 0; i < 8 && i < head_q.size(); i++) hv[i] = head_q[i];
        chk("a5_head_bits", hv, 8'hA5);
        chk("a5_fetches", fetch_q.size(), 1);

        mem[0] = 32'hDEAD_BEEF;
        mem[1] = 32'h0000_005A;
        do_run(40, 1'b1, 0, 1'b0, -1, "v40", lat);
        do_run(40, 1'b1, 0, 1'b1, -1, "tail0", lat);
        chk("tail0_err_28", err_cnt, 28);
        do_run(40, 1'b1, 5, 1'b0, -1, "stall", lat);

        do_run(0, 1'b1, 0, 1'b0, -1, "n0", lat);
        chk("n0_latency_le2", (lat <= 2 && lat >= 1), 1);
        chk("n0_no_req", req_cnt, 0);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 4; i++) mem[i] = $urandom;
            n     = $urandom_range(1, 100);
            vf    = 1'($urandom_range(0, 1));
            flipk = (vf && $urandom_range(0, 1) == 1) ? $urandom_range(0, n - 1) : -1;
            do_run(n, vf, $urandom_range(0, 3), 1'b0, flipk, $sformatf("rnd%0d", r), lat);
        end

        mem[0] = $urandom; mem[1] = $urandom;
        ack_delay = 0;
        clr_req++;
        start = 1'b1; verify = 1'b0; cfg_nbits = CNT_W'(64);
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 200 && rises < 1; c++) @(negedge clk);
        start = 1'b1; cfg_nbits = CNT_W'(5);
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 200 && rises < 3; c++) @(negedge clk);
        chk("abort_rises_before", rises, 3);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_prog_clk", prog_clk, 0);
        chk("abort_mem_req", mem_req, 0);
        chk("abort_pass", pass, 0);
        chk("abort_single_fetch", fetch_q.size(), 1);
        hv = '0;
        for (int i = 0; i < 3 && i < head_q.size(); i++) hv[i] = head_q[i];
        chk("abort_head_bits", hv, {5'b0, stream_bit(2), stream_bit(1), stream_bit(0)});
        repeat (5) @(negedge clk);
        chk("abort_no_done", done_cnt, 0);
        chk("abort_no_more_rises", rises, 3);

        do_run(40, 1'b1, 0, 1'b0, -1, "restart", lat);

        mem[0] = 32'hDEAD_BEEF;
        mem[1] = 32'h0000_005A;
        force0 = 1'b1;
        tail_idx = 39;
        clr_req++;
        start = 1'b1; verify = 1'b1; cfg_nbits = CNT_W'(40);
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 400 && rises < 50; c++) @(negedge clk);
        chk("midreset_err_nonzero", (err_cnt != 0), 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk_reset_outputs("midreset");
        @(negedge clk);
        reset  = 1'b0;
        force0 = 1'b0;
        repeat (3) @(negedge clk);
        chk("midreset_no_done", done_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ccff_prog_ctrl.md
Name: ccff_prog_ctrl

Overview:
Sequencer that programs the FPGA fabric configuration chain (ccff_head/ccff_tail scan chain, clocked by prog_clk) from a word-wide bitstream memory. It fetches words, serialises them LSB-first onto ccff_head and generates prog_clk. It can optionally re-shift the same bitstream and compare ccff_tail against it to confirm the load. It sits between the bitstream store and the fabric, ahead of the formal top-level used by the verification benches.

Parameters:
WORD_W, 32, bitstream memory word width
ADDR_W, 10, memory word-address width
CNT_W, 16, width of bit counter and cfg_nbits
HALF_PER, 1, clk cycles per prog_clk half-period (>=1)

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  begin programming; sampled only in IDLE
verify  in  1  sampled with start; 1 = run a second compare pass
abort  in  1  return to IDLE next cycle
cfg_nbits  in  CNT_W  configuration chain length in bits; sampled with start
mem_req  out  1  word read request; level, held until mem_ack
mem_addr  out  ADDR_W  word address; stable while mem_req=1
mem_ack  in  1  one-cycle strobe; mem_rdata valid in the same cycle
mem_rdata  in  WORD_W  bitstream word
prog_clk  out  1  chain shift clock (registered)
ccff_head  out  1  serial data into chain (registered)
ccff_tail  in  1  serial data out of chain
busy  out  1  high from the cycle after an accepted start until DONE
done  out  1  one-cycle pulse at completion
pass  out  1  sticky result; cleared on accepted start
err_cnt  out  16  saturating count of compare mismatches; cleared on accepted start

Behaviour:
- Reset: state IDLE; mem_req=0, mem_addr=0, prog_clk=0, ccff_head=0, busy=0, done=0, pass=0, err_cnt=0. Reset mid-operation aborts with no done pulse; prog_clk returns low.
- States: IDLE, FETCH, SHIFT_LO, SHIFT_HI, DONE.
- IDLE: start=1 latches cfg_nbits and verify, clears pass and err_cnt, sets pass_no=0, addr=0, bit_cnt=0. If cfg_nbits=0, go to DONE; otherwise go to FETCH. start while busy is ignored.
- FETCH: mem_req=1 with mem_addr=addr; prog_clk held 0. On mem_ack, latch mem_rdata into the shift word, set word_idx=0, addr+1, go to SHIFT_LO. There is no timeout.
- SHIFT_LO: prog_clk=0 and ccff_head=word[word_idx] for HALF_PER cycles. ccff_head changes only on entry to SHIFT_LO, so it is stable for the whole high phase. If pass_no=1, in the last SHIFT_LO cycle compare ccff_tail with word[word_idx]; on mismatch, err_cnt+1 saturating at 0xFFFF.
- SHIFT_HI: prog_clk=1 for HALF_PER cycles, then bit_cnt+1. Next state:
  - bit_cnt==cfg_nbits: if verify=1 and pass_no=0, set pass_no=1, addr=0, bit_cnt=0, go to FETCH; otherwise go to DONE.
  - word_idx==WORD_W-1: go to FETCH.
  - otherwise: word_idx+1, go to SHIFT_LO.
- Bits of the final word above cfg_nbits are never shifted. Words fetched per pass = ceil(cfg_nbits/WORD_W).
- Compare pass: the chain emits first-in bit first, so bit k of pass 1 is expected on ccff_tail before the k-th rising prog_clk edge of pass 2.
- DONE: done=1 for one cycle; pass=1 iff err_cnt==0 (also 1 when verify=0); then go to IDLE. busy=0 in IDLE and DONE.
- abort (any non-IDLE state): go to IDLE next cycle; prog_clk=0, mem_req=0, pass=0, no done pulse. abort has priority over mem_ack and shift completion in the same cycle.
- Exactly cfg_nbits rising prog_clk edges per pass; prog_clk high time = low time = HALF_PER cycles during shifting; prog_clk stays low while stalled in FETCH.
- mem_addr wraps modulo 2^ADDR_W.

Test Plan:
- cfg_nbits=8, verify=0, word0=0x000000A5, HALF_PER=1: ccff_head sequence is 1,0,1,0,0,1,0,1; exactly 8 prog_clk rises; one fetch; done pulse; pass=1.
- cfg_nbits=40, verify=1, words 0xDEADBEEF and 0x0000005A, behavioural 40-bit shift-register chain model: 2 fetches per pass (addr 0,1 twice); 80 prog_clk rises; done with pass=1, err_cnt=0.
- Same as previous, but ccff_tail forced to 0: err_cnt=popcount of the 40 bits=28; pass=0.
- mem_ack delayed 5 cycles on every fetch: mem_req and mem_addr held stable; prog_clk stays low during the stall; final result matches the no-delay run.
- cfg_nbits=0: done within 2 cycles of start; no mem_req; no prog_clk edge; pass=1.
- abort after 3 bits, then start pulsed while busy (earlier run): the start while busy is ignored; abort gives IDLE next cycle with prog_clk=0, no done pulse, pass=0. A subsequent start reprograms from addr 0. Reset asserted mid-shift gives all outputs at reset values in the following cycle.
